iic_slave: RTL and testbench
============================

IIC_SLAVE -- requirements
Module: iic_slave

Interface
REQ-001 SHALL have parameter S_1, 26 bits, default 26'd50_000_000: bus-stall timeout in clk cycles.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic rises on clk.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-high despite the name.
REQ-004 SHALL have port SCL, input, 1 bit: I2C clock from master, asynchronous, always an input.
REQ-005 SHALL have port SDA_in, input, 1 bit: sampled I2C data line, asynchronous.
REQ-006 SHALL have port SDA_out, output reg, 1 bit: value the slave drives on SDA.
REQ-007 SHALL have port SDA_oe, output reg, 1 bit: 1 means drive SDA_out, 0 means release SDA (high-Z).

Function
REQ-008 SHALL pass SCL and SDA_in through 2-FF synchronizers and derive one-cycle pulses SCL_podge (rising) and SCL_nedge (falling).
REQ-009 SHALL keep cnt_SCL_low: cleared on SCL_nedge, incremented each clk while synced SCL is low, saturating, held at 0 while SCL is high.
REQ-010 SHALL define CHANGE_TIME = 10 clk; every SDA_out/SDA_oe change occurs in the cycle cnt_SCL_low == CHANGE_TIME.
REQ-011 SHALL sample the SDA bit on SCL_podge, MSB first.
REQ-012 SHALL detect START as synced SDA falling while SCL high, and STOP as synced SDA rising while SCL high; both are legal in any state.
REQ-013 SHALL, on START (including repeated START), clear the bit counter and enter DEV_ADDR.
REQ-014 SHALL, on STOP, release SDA and enter IDLE.
REQ-015 SHALL implement states IDLE, DEV_ADDR, ACK_DEV, WORD_ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, RD_ACK, WAIT_STOP.
REQ-016 SHALL, in DEV_ADDR, receive 8 bits; upper 7 bits == 7'b1010000 then go to ACK_DEV, else go to WAIT_STOP with SDA released (NACK).
REQ-017 SHALL, in ACK_DEV, drive 0 during the 9th clock; R/W=0 then go to WORD_ADDR; R/W=1 then go to RD_DATA.
REQ-018 SHALL, in WORD_ADDR, receive 8 bits into the address pointer, ACK in ACK_ADDR, then go to WR_DATA.
REQ-019 SHALL, in WR_DATA, receive 8 bits, write mem[ptr] on the 8th SCL_podge, ACK in ACK_WR, then increment ptr.
REQ-020 SHALL make a START arriving in WR_DATA before any data bit switch to DEV_ADDR (random-read setup) without writing.
REQ-021 SHALL, in RD_DATA, load mem[ptr] at entry and drive its 8 bits MSB first with SDA_oe=1, then release SDA for RD_ACK.
REQ-022 SHALL sample the master bit in RD_ACK: 0 (ACK) then increment ptr and return to RD_DATA; 1 (NACK) then go to WAIT_STOP.
REQ-023 SHALL keep ptr 8 bits, wrapping 0xFF to 0x00 with no page limit, for both reads and writes.
REQ-024 SHALL, in WAIT_STOP, ignore everything except START and STOP.
REQ-025 SHALL, outside IDLE, go to IDLE with SDA released if no SCL edge occurs for S_1 consecutive clk cycles.

Reset
REQ-026 SHALL, while rst_n=1 at clk edge, set state IDLE, SDA_out=1, SDA_oe=0, ptr=0, bit counter and cnt_SCL_low cleared, synchronizers set to 1.
REQ-027 SHALL leave memory contents unchanged by reset, with no initial value guaranteed.
REQ-028 SHALL abandon a reset asserted mid-transfer immediately, with no memory write.

Structure
REQ-029 SHALL place the state encoding, device address 7'b1010000 and CHANGE_TIME in a shared package iic_pkg.
REQ-030 SHALL instantiate one sub-module iic_ram: 256x8, 1 synchronous write port and 1 read port.

Verification
REQ-031 SHALL cover a write burst: START, A0, 23, 8 random bytes, STOP -> ACK on all 10 bytes, mem[0x23..0x2A] equal the bytes.
REQ-032 SHALL cover a random read: START, A0, 25, START, A1, ACK x4, NACK, STOP -> mem[0x25..0x29] returned MSB first, SDA released after NACK.
REQ-033 SHALL cover a wrong address: START, 0xA2 -> no ACK (SDA_oe=0), and the next STOP then valid START is accepted.
REQ-034 SHALL cover wrap: write to 0xFF then 2 bytes -> second byte lands at 0x00; sequential read from 0xFF wraps likewise.
REQ-035 SHALL cover timeout with S_1=100: stop SCL mid-byte -> IDLE and SDA_oe=0 within 100 clk.
REQ-036 SHALL cover reset: assert rst_n mid-read -> SDA_oe=0 and SDA_out=1 next cycle.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared definitions for the I2C EEPROM-style slave: FSM encoding,
// the 7-bit device address and the SDA change point inside SCL low.
package iic_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        DEV_ADDR  = 4'd1,
        ACK_DEV   = 4'd2,
        WORD_ADDR = 4'd3,
        ACK_ADDR  = 4'd4,
        WR_DATA   = 4'd5,
        ACK_WR    = 4'd6,
        RD_DATA   = 4'd7,
        RD_ACK    = 4'd8,
        WAIT_STOP = 4'd9
    } iic_state_t;

    // 7-bit slave address; the 8th bit of the address byte is R/W.
    localparam logic [6:0] DEVICE_ADDR = 7'b1010000;

    // clk cycles after the synced SCL falling edge at which SDA may move.
    localparam logic [7:0] CHANGE_TIME = 8'd10;

endpackage

// File: rtl/iic_ram.sv
// 256x8 storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module iic_ram (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [0:255];

    // Write port: one byte per enabled clock.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/iic_slave.sv
// I2C slave with a 256-byte memory, 8-bit auto-incrementing pointer that
// wraps with no page limit. SCL/SDA are oversampled on clk; the slave only
// moves SDA a fixed number of clk cycles into each SCL low phase, except that
// STOP, bus timeout and reset release SDA immediately.
module iic_slave #(
    parameter logic [25:0] S_1 = 26'd50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SCL,
    input  logic SDA_in,
    output logic SDA_out,
    output logic SDA_oe
);

    import iic_pkg::*;

    logic       scl_s1, scl_s2, scl_d;
    logic       sda_s1, sda_s2, sda_d;
    logic       SCL_podge, SCL_nedge;
    logic       start_det, stop_det;
    logic [7:0] cnt_SCL_low;
    logic       change_now;
    logic [25:0] to_cnt;
    logic       timeout;

    iic_state_t state, state_nxt;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       rx_state;
    logic [7:0] ptr;
    logic       rw;
    logic [7:0] rd_byte;
    logic       load_rd;
    logic       drive_oe, drive_out;

    logic       ram_we;
    logic [7:0] ram_rd_data;

    // Two-flop synchronizers plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            scl_s1 <= SCL;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= SDA_in;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign SCL_podge = scl_s2 & ~scl_d;
    assign SCL_nedge = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

    // Length of the current SCL low phase, saturating; zero while SCL is high.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            cnt_SCL_low <= '0;
        end else if (SCL_nedge || scl_s2) begin
            cnt_SCL_low <= '0;
        end else if (cnt_SCL_low != 8'hFF) begin
            cnt_SCL_low <= cnt_SCL_low + 8'd1;
        end
    end

    assign change_now = ~scl_s2 && (cnt_SCL_low == CHANGE_TIME);

    // Stall watchdog: counts clk cycles since the last SCL edge outside IDLE.
    always_ff @(posedge clk) begin
        if (rst_n || state == IDLE || SCL_podge || SCL_nedge) begin
            to_cnt <= '0;
        end else if (!timeout) begin
            to_cnt <= to_cnt + 26'd1;
        end
    end

    assign timeout = (state != IDLE) && !SCL_podge && !SCL_nedge
                     && (to_cnt == S_1 - 26'd1);

    assign rx_byte   = {shift, sda_s2};
    assign rx_state  = (state == DEV_ADDR) || (state == WORD_ADDR)
                       || (state == WR_DATA) || (state == RD_DATA);
    assign byte_done = SCL_podge && (bit_cnt == 3'd7);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: STOP/timeout and START override every state.
    always_comb begin
        state_nxt = state;
        if (stop_det || timeout) begin
            state_nxt = IDLE;
        end else if (start_det) begin
            state_nxt = DEV_ADDR;
        end else begin
            case (state)
                IDLE, WAIT_STOP: state_nxt = state;
                DEV_ADDR: if (byte_done) begin
                    state_nxt = (rx_byte[7:1] == DEVICE_ADDR) ? ACK_DEV : WAIT_STOP;
                end
                ACK_DEV:   if (SCL_podge) state_nxt = rw ? RD_DATA : WORD_ADDR;
                WORD_ADDR: if (byte_done) state_nxt = ACK_ADDR;
                ACK_ADDR:  if (SCL_podge) state_nxt = WR_DATA;
                WR_DATA:   if (byte_done) state_nxt = ACK_WR;
                ACK_WR:    if (SCL_podge) state_nxt = WR_DATA;
                RD_DATA:   if (byte_done) state_nxt = RD_ACK;
                RD_ACK:    if (SCL_podge) state_nxt = sda_s2 ? WAIT_STOP : RD_DATA;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // FSM output decode: the SDA level wanted at the next change point.
    always_comb begin
        drive_oe  = 1'b0;
        drive_out = 1'b1;
        case (state)
            ACK_DEV, ACK_ADDR, ACK_WR: begin
                drive_oe  = 1'b1;
                drive_out = 1'b0;
            end
            RD_DATA: begin
                drive_oe  = 1'b1;
                drive_out = rd_byte[~bit_cnt];
            end
            default: begin
                drive_oe  = 1'b0;
                drive_out = 1'b1;
            end
        endcase
    end

    // SDA pins: move only at the change point; release at once on STOP/timeout.
    always_ff @(posedge clk) begin
        if (rst_n || stop_det || timeout) begin
            SDA_out <= 1'b1;
            SDA_oe  <= 1'b0;
        end else if (change_now) begin
            SDA_out <= drive_out;
            SDA_oe  <= drive_oe;
        end
    end

    // Bit counter, receive shifter, pointer, R/W flag and transmit byte.
    // The transmit byte is fetched one cycle after entering RD_DATA so the
    // pointer increment from RD_ACK has already landed.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            load_rd <= 1'b0;
            rd_byte <= '0;
        end else begin
            load_rd <= (state_nxt == RD_DATA) && (state != RD_DATA);
            if (load_rd) begin
                rd_byte <= ram_rd_data;
            end
            if (start_det || stop_det || timeout) begin
                bit_cnt <= '0;
            end else if (SCL_podge && rx_state) begin
                shift   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (state == DEV_ADDR && byte_done) begin
                rw <= sda_s2;
            end
            if (state == WORD_ADDR && byte_done) begin
                ptr <= rx_byte;
            end else if (state == ACK_WR && SCL_podge) begin
                ptr <= ptr + 8'd1;
            end else if (state == RD_ACK && SCL_podge && !sda_s2) begin
                ptr <= ptr + 8'd1;
            end
        end
    end

    assign ram_we = !rst_n && (state == WR_DATA) && byte_done;

    iic_ram u_ram (
        .clk     (clk),
        .we      (ram_we),
        .wr_addr (ptr),
        .wr_data (rx_byte),
        .rd_addr (ptr),
        .rd_data (ram_rd_data)
    );

endmodule

// File: tb/tb_iic_slave.sv
// Directed bench for iic_slave: an open-drain bus model, a bit-level I2C
// master driver, and a scoreboard queue of expected read bytes.
module tb_iic_slave;

    localparam int Q = 20;

    logic clk = 1'b0;
    logic rst_n;
    logic scl;
    logic msda;
    logic sda_bus;
    logic sda_out;
    logic sda_oe;

    int n_checks;
    int n_fail;
    logic [7:0] exp_q[$];

    logic [7:0] wr_tbl [8] = '{8'h5A, 8'hC3, 8'h01, 8'hFF, 8'h80, 8'h7E, 8'h00, 8'h96};

    assign sda_bus = msda & (sda_oe ? sda_out : 1'b1);

    iic_slave #(.S_1(26'd100)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SCL     (scl),
        .SDA_in  (sda_bus),
        .SDA_out (sda_out),
        .SDA_oe  (sda_oe)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Absolute time limit.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period starting and ending with SCL low.
    task automatic clock_bit(input logic m, output logic bus_bit, output logic oe_bit);
        wait_clk(Q);
        msda = m;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        bus_bit = sda_bus;
        oe_bit  = sda_oe;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic start_cond();
        msda = 1'b1;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        msda = 1'b0;
        wait_clk(Q);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(Q);
        msda = 1'b0;
        wait_clk(Q);
        scl = 1'b1;
        wait_clk(Q);
        msda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic send_byte(input string tag, input logic [7:0] b, input logic exp_ack);
        logic bb, oo;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(b[i], bb, oo);
        end
        clock_bit(1'b1, bb, oo);
        check_eq(tag, {31'd0, (bb == 1'b0) && oo}, {31'd0, exp_ack});
    endtask

    task automatic read_check(input string tag, input logic nack);
        logic bb, oo;
        logic [7:0] d;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, bb, oo);
            d[i] = bb;
        end
        clock_bit(nack, bb, oo);
        check_eq(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
        check_eq({tag, "_release"}, {31'd0, oo}, 32'd0);
    endtask

    initial begin
        logic bb, oo;
        int elapsed;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b1;
        scl   = 1'b1;
        msda  = 1'b1;
        wait_clk(5);
        check_eq("reset_oe", {31'd0, sda_oe}, 32'd0);
        check_eq("reset_out", {31'd0, sda_out}, 32'd1);
        check_eq("reset_state", {28'd0, dut.state}, {28'd0, iic_pkg::IDLE});
        rst_n = 1'b0;
        wait_clk(5);

        // Write burst at 0x23.
        start_cond();
        send_byte("wr_dev_ack", 8'hA0, 1'b1);
        send_byte("wr_addr_ack", 8'h23, 1'b1);
        for (int k = 0; k < 8; k++) begin
            send_byte($sformatf("wr_data_ack%0d", k), wr_tbl[k], 1'b1);
        end
        stop_cond();
        check_eq("wr_stop_idle", {28'd0, dut.state}, {28'd0, iic_pkg::IDLE});

        // Random read of 0x25..0x29.
        start_cond();
        send_byte("rr_dev_ack", 8'hA0, 1'b1);
        send_byte("rr_addr_ack", 8'h25, 1'b1);
        start_cond();
        send_byte("rr_rdev_ack", 8'hA1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            exp_q.push_back(wr_tbl[2 + k]);
        end
        for (int k = 0; k < 5; k++) begin
            read_check($sformatf("rr_data%0d", k), k == 4);
        end
        wait_clk(15);
        check_eq("rr_nack_oe", {31'd0, sda_oe}, 32'd0);
        stop_cond();
        check_eq("rr_stop_idle", {28'd0, dut.state}, {28'd0, iic_pkg::IDLE});

        // Wrong device address, then a valid one.
        start_cond();
        send_byte("bad_dev_nack", 8'hA2, 1'b0);
        check_eq("bad_dev_state", {28'd0, dut.state}, {28'd0, iic_pkg::WAIT_STOP});
        stop_cond();
        start_cond();
        send_byte("good_dev_ack", 8'hA0, 1'b1);
        stop_cond();

        // Pointer wrap on write and on sequential read.
        start_cond();
        send_byte("wrap_dev_ack", 8'hA0, 1'b1);
        send_byte("wrap_addr_ack", 8'hFF, 1'b1);
        send_byte("wrap_d0_ack", 8'h3C, 1'b1);
        send_byte("wrap_d1_ack", 8'hC5, 1'b1);
        stop_cond();
        start_cond();
        send_byte("wrap_rdev_ack", 8'hA0, 1'b1);
        send_byte("wrap_raddr_ack", 8'hFF, 1'b1);
        start_cond();
        send_byte("wrap_rrdev_ack", 8'hA1, 1'b1);
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC5);
        read_check("wrap_rd_ff", 1'b0);
        read_check("wrap_rd_00", 1'b1);
        stop_cond();

        // Reset in the middle of a read of 0x23 (0x5A, MSB is 0).
        start_cond();
        send_byte("rst_dev_ack", 8'hA0, 1'b1);
        send_byte("rst_addr_ack", 8'h23, 1'b1);
        start_cond();
        send_byte("rst_rdev_ack", 8'hA1, 1'b1);
        wait_clk(Q);
        check_eq("rst_pre_oe", {31'd0, sda_oe}, 32'd1);
        check_eq("rst_pre_out", {31'd0, sda_out}, 32'd0);
        rst_n = 1'b1;
        wait_clk(1);
        check_eq("rst_mid_oe", {31'd0, sda_oe}, 32'd0);
        check_eq("rst_mid_out", {31'd0, sda_out}, 32'd1);
        rst_n = 1'b0;
        check_eq("rst_mid_state", {28'd0, dut.state}, {28'd0, iic_pkg::IDLE});
        scl = 1'b1;
        wait_clk(Q);
        start_cond();
        send_byte("post_rst_dev_ack", 8'hA0, 1'b1);
        send_byte("post_rst_addr_ack", 8'h23, 1'b1);
        start_cond();
        send_byte("post_rst_rdev_ack", 8'hA1, 1'b1);
        exp_q.push_back(8'h5A);
        read_check("post_rst_rd", 1'b1);
        stop_cond();

        // Bus stall while the slave drives ACK.
        start_cond();
        for (int i = 7; i >= 0; i--) begin
            clock_bit(i == 5 || i == 7, bb, oo);
        end
        wait_clk(Q);
        check_eq("to_ack_drive", {31'd0, sda_oe}, 32'd1);
        elapsed = Q;
        while (sda_oe && elapsed < 150) begin
            wait_clk(1);
            elapsed++;
        end
        check_eq("to_release", {31'd0, sda_oe}, 32'd0);
        check_eq("to_state", {28'd0, dut.state}, {28'd0, iic_pkg::IDLE});
        check_eq("to_window", {31'd0, (elapsed >= 95) && (elapsed <= 110)}, 32'd1);
        stop_cond();
        start_cond();
        send_byte("to_post_dev_ack", 8'hA0, 1'b1);
        send_byte("to_post_addr_ack", 8'h24, 1'b1);
        start_cond();
        send_byte("to_post_rdev_ack", 8'hA1, 1'b1);
        exp_q.push_back(wr_tbl[1]);
        read_check("to_post_rd", 1'b1);
        stop_cond();

        check_eq("exp_q_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
